// File: rtl/arb_client_port.sv
// Requester-side port for the shared round-robin arbiter: buffers client words in a
// small FIFO, requests only for words not already covered by an in-flight grant.
module arb_client_port #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_data,
    output logic                   req,
    input  logic                   gnt,
    output logic                   bus_valid,
    output logic [DW-1:0]          bus_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   spurious_gnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_bus_valid;
    logic [DW-1:0] r_bus_data;
    logic          r_spurious;

    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_next;

    // FIFO handshake decode and occupancy update
    always_comb begin
        w_empty      = (r_count == {CW{1'b0}});
        w_push       = in_valid & (r_count < FULL);
        w_pop        = gnt & ~w_empty;
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // A grant already in flight covers one buffered word, so it is excluded from req.
    assign req          = (r_count > {{AW{1'b0}}, gnt});
    assign in_ready     = (r_count < FULL);
    assign level        = r_count;
    assign bus_valid    = r_bus_valid;
    assign bus_data     = r_bus_data;
    assign spurious_gnt = r_spurious;

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Storage array is deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Registered shared-bus output; data holds between pops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_valid <= 1'b0;
            r_bus_data  <= {DW{1'b0}};
        end else if (w_pop) begin
            r_bus_valid <= 1'b1;
            r_bus_data  <= r_mem[r_rd_ptr];
        end else begin
            r_bus_valid <= 1'b0;
        end
    end

    // Sticky flag for a grant that found nothing to send
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spurious <= 1'b0;
        end else if (gnt & w_empty) begin
            r_spurious <= 1'b1;
        end
    end

endmodule
